seg_scan_drv: RTL and testbench

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

---
 rtl/seg_scan_drv.sv | 218 +++++++++++++++++++++
 tb/tb_seg_scan_drv.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed 7-segment scan driver with a shadow register and a one-clock anti-ghost gap.
// Optional blink highlight is compiled in only when SEG_SCAN_BLINK_EN is defined.
module seg_scan_drv #(
    parameter int unsigned CLK_IN_FREQ = 27000000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned BLINK_HZ    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits_i,
    input  logic [3:0]  dp_i,
    input  logic [3:0]  blank_i,
    input  logic [3:0]  blink_i,
    input  logic        load_i,
    output logic [3:0]  sel_seg,
    output logic [7:0]  seg_led
);

    localparam int unsigned SCAN_DIV_RAW = CLK_IN_FREQ / SCAN_HZ;
    localparam int unsigned SCAN_DIV     = (SCAN_DIV_RAW > 0) ? SCAN_DIV_RAW : 1;
    localparam int unsigned SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    logic [SCAN_W-1:0] r_presc;
    logic              w_tick;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_idx;
    logic [1:0]        r_cur;

    logic [15:0]       r_sh_dig;
    logic [3:0]        r_sh_dp;
    logic [3:0]        r_sh_blank;

    logic [7:0]        r_pat;
    logic [7:0]        w_pat_nxt;
    logic [7:0]        w_pat_live;
    logic [3:0]        w_nib;
    logic [3:0]        w_sel_nxt;
    logic [7:0]        w_seg_nxt;
    logic              w_gap_mask;
    logic              w_show_mask;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Scan prescaler: tick on terminal count, then wrap.
    assign w_tick = (r_presc == SCAN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + SCAN_W'(1);
        end
    end

    // r_idx is the next digit to show; r_cur is the digit being shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
            r_cur <= 2'd0;
        end else if (w_tick) begin
            r_cur <= r_idx;
            r_idx <= r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_dig   <= 16'h0000;
            r_sh_dp    <= 4'h0;
            r_sh_blank <= 4'h0;
        end else if (load_i) begin
            r_sh_dig   <= digits_i;
            r_sh_dp    <= dp_i;
            r_sh_blank <= blank_i;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int unsigned BLINK_DIV_RAW = CLK_IN_FREQ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_DIV     = (BLINK_DIV_RAW > 0) ? BLINK_DIV_RAW : 1;
    localparam int unsigned BLINK_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [BLINK_W-1:0] r_bcnt;
    logic               r_phase;
    logic [3:0]         r_sh_blink;
    logic               r_blk_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == BLINK_LAST) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + BLINK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_blink <= 4'h0;
        end else if (load_i) begin
            r_sh_blink <= blink_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_sel <= 1'b0;
        end else if (!w_tick && (r_state == S_GAP)) begin
            r_blk_sel <= r_sh_blink[r_cur];
        end
    end

    assign w_gap_mask  = r_sh_blink[r_cur] & r_phase;
    assign w_show_mask = r_blk_sel & r_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_i;
    assign w_gap_mask     = 1'b0;
    assign w_show_mask    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Any tick opens a gap; the gap always resolves into a held digit.
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            w_state_nxt = S_GAP;
        end else if (r_state == S_GAP) begin
            w_state_nxt = S_SHOW;
        end
    end

    always_comb begin
        w_nib = 4'h0;
        case (r_cur)
            2'd0:    w_nib = r_sh_dig[3:0];
            2'd1:    w_nib = r_sh_dig[7:4];
            2'd2:    w_nib = r_sh_dig[11:8];
            default: w_nib = r_sh_dig[15:12];
        endcase
    end

    // Blank overrides both dp and decoded segments.
    assign w_pat_live = r_sh_blank[r_cur] ? 8'h00 : {r_sh_dp[r_cur], seg_decode(w_nib)};

    always_comb begin
        w_sel_nxt = sel_seg;
        w_seg_nxt = seg_led;
        w_pat_nxt = r_pat;
        if (w_tick) begin
            w_sel_nxt = 4'b1111;
            w_seg_nxt = 8'h00;
        end else begin
            case (r_state)
                S_GAP: begin
                    w_sel_nxt = ~(4'b0001 << r_cur);
                    w_pat_nxt = w_pat_live;
                    w_seg_nxt = w_gap_mask ? 8'h00 : w_pat_live;
                end
                S_SHOW: begin
                    w_seg_nxt = w_show_mask ? 8'h00 : r_pat;
                end
                default: begin
                    w_sel_nxt = 4'b1111;
                    w_seg_nxt = 8'h00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_seg <= 4'b1111;
            seg_led <= 8'h00;
            r_pat   <= 8'h00;
        end else begin
            sel_seg <= w_sel_nxt;
            seg_led <= w_seg_nxt;
            r_pat   <= w_pat_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed self-checking bench for seg_scan_drv (tick every 4 clocks, blink phase every 20 clocks).
// Blink expectations follow SEG_SCAN_BLINK_EN exactly as the design does.
module tb_seg_scan_drv;

    logic        clk;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  dp_i;
    logic [3:0]  blank_i;
    logic [3:0]  blink_i;
    logic        load_i;
    logic [3:0]  sel_seg;
    logic [7:0]  seg_led;

    int n_cmp;
    int n_bad;
    int cyc;

    seg_scan_drv #(
        .CLK_IN_FREQ (40),
        .SCAN_HZ     (10),
        .BLINK_HZ    (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .digits_i (digits_i),
        .dp_i     (dp_i),
        .blank_i  (blank_i),
        .blink_i  (blink_i),
        .load_i   (load_i),
        .sel_seg  (sel_seg),
        .seg_led  (seg_led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge count since reset release; after edge k, cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_to(input int n);
        int guard;
        guard = 0;
        while (cyc != n && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk("step_to", 32'(cyc), 32'(n));
    endtask

    task automatic expect_at(input string tag, input int n, input logic [3:0] sel, input logic [7:0] seg);
        step_to(n);
        chk({tag, "_sel"}, 32'(sel_seg), 32'(sel));
        chk({tag, "_seg"}, 32'(seg_led), 32'(seg));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        digits_i = 16'h0000;
        dp_i     = 4'h0;
        blank_i  = 4'h0;
        blink_i  = 4'h0;
        load_i   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_sel", 32'(sel_seg), 32'h0000000F);
        chk("rst_seg", 32'(seg_led), 32'h00000000);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk);
        digits_i = d;
        dp_i     = dp;
        blank_i  = bl;
        blink_i  = bk;
        load_i   = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_seg;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        digits_i = 16'h0000;
        dp_i     = 4'h0;
        blank_i  = 4'h0;
        blink_i  = 4'h0;
        load_i   = 1'b0;

        // Scan order with gap cycles
        do_reset();
        load(16'h1234, 4'h0, 4'h0, 4'h0);
        expect_at("pre_tick", 3, 4'b1111, 8'h00);
        expect_at("gap0", 4, 4'b1111, 8'h00);
        expect_at("dig0", 5, 4'b1110, 8'h66);
        expect_at("hold0", 7, 4'b1110, 8'h66);
        expect_at("gap1", 8, 4'b1111, 8'h00);
        expect_at("dig1", 9, 4'b1101, 8'h4F);
        expect_at("gap2", 12, 4'b1111, 8'h00);
        expect_at("dig2", 13, 4'b1011, 8'h5B);
        expect_at("gap3", 16, 4'b1111, 8'h00);
        expect_at("dig3", 17, 4'b0111, 8'h06);
        expect_at("wrap0", 21, 4'b1110, 8'h66);

        // Decode, dp and out-of-range nibble
        do_reset();
        load(16'hF900, 4'b0100, 4'h0, 4'h0);
        expect_at("dec0", 5, 4'b1110, 8'h3F);
        expect_at("dec1", 9, 4'b1101, 8'h3F);
        expect_at("dec2_dp", 13, 4'b1011, 8'hEF);
        expect_at("dec3_f", 17, 4'b0111, 8'h00);

        // Blank overrides dp
        do_reset();
        load(16'h0008, 4'b0001, 4'b0001, 4'h0);
        expect_at("blank0", 5, 4'b1110, 8'h00);
        expect_at("blank1", 9, 4'b1101, 8'h3F);

        // Blink on digit 1 (value 5)
        do_reset();
        load(16'h0050, 4'h0, 4'h0, 4'b0010);
        for (int c = 9; c < 96; c++) begin
            if ((c % 16) >= 9 && (c % 16) <= 11) begin
`ifdef SEG_SCAN_BLINK_EN
                exp_seg = ((((c - 1) / 20) % 2) == 1) ? 8'h00 : 8'h6D;
`else
                exp_seg = 8'h6D;
`endif
                expect_at("blink", c, 4'b1101, exp_seg);
            end
        end

        // Load coincident with a tick reaches the newly selected digit
        do_reset();
        load(16'h0030, 4'h0, 4'h0, 4'h0);
        expect_at("ld_before", 9, 4'b1101, 8'h4F);
        step_to(23);
        load(16'h0070, 4'h0, 4'h0, 4'h0);
        expect_at("ld_tick", 25, 4'b1101, 8'h07);
        digits_i = 16'h0090;
        expect_at("ld_none", 41, 4'b1101, 8'h07);

        // Asynchronous reset between edges
        do_reset();
        load(16'h1234, 4'h0, 4'h0, 4'h0);
        expect_at("pre_ar", 6, 4'b1110, 8'h66);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(sel_seg), 32'h0000000F);
        chk("ar_seg", 32'(seg_led), 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at("ar_wait", 3, 4'b1111, 8'h00);
        expect_at("ar_gap", 4, 4'b1111, 8'h00);
        expect_at("ar_first", 5, 4'b1110, 8'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
